// File: rtl/bmu_pkg.sv
// Shared BMU definitions: opcode encodings (common with the single-cycle BMU)
// and the multicycle FSM state type.
package bmu_pkg;

    localparam logic [4:0] OP_CLMUL  = 5'b00001;
    localparam logic [4:0] OP_CLMULH = 5'b00010;
    localparam logic [4:0] OP_CLMULR = 5'b00011;
    localparam logic [4:0] OP_CLZ    = 5'b00100;
    localparam logic [4:0] OP_CPOP   = 5'b00101;
    localparam logic [4:0] OP_CTZ    = 5'b00110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The multicycle unit implements the contiguous opcode range CLMUL..CTZ.
    function automatic logic isLegalOp(input logic [4:0] op);
        return (op >= OP_CLMUL) && (op <= OP_CTZ);
    endfunction

endpackage

// File: rtl/bmu_multicycle.sv
// Bit-serial BMU: carry-less multiply family, CLZ, CTZ and CPOP, one operand
// bit per cycle over a fixed 32-cycle run.
module bmu_multicycle
    import bmu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        flush_i,
    input  logic [4:0]  BMU_OP_i,
    input  logic [31:0] BMU_RS1_i,
    input  logic [31:0] BMU_RS2_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [4:0]  r_op;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [63:0] r_acc;
    logic [5:0]  r_count;
    logic        r_found;
    logic        r_done;
    logic [31:0] r_result;

    logic [4:0]  w_clzIdx;
    logic        w_scanBit;
    logic [63:0] w_accNext;
    logic [5:0]  w_countNext;
    logic        w_foundNext;
    logic [31:0] w_finalResult;

    assign busy_o   = (r_state == ST_RUN);
    assign done_o   = r_done;
    assign result_o = r_result;

    // Per-step datapath; the final result is taken from the post-step values
    // so bit 31 is included on the cycle the FSM leaves RUN.
    always_comb begin
        w_clzIdx    = 5'd31 - r_cnt;
        w_scanBit   = (r_op == OP_CLZ) ? r_rs1[w_clzIdx] : r_rs1[r_cnt];
        w_accNext   = r_acc;
        w_countNext = r_count;
        w_foundNext = r_found;
        if (r_rs2[r_cnt]) begin
            w_accNext = r_acc ^ ({32'b0, r_rs1} << r_cnt);
        end
        if (r_op == OP_CPOP) begin
            if (r_rs1[r_cnt]) begin
                w_countNext = r_count + 6'd1;
            end
        end else if ((r_op == OP_CLZ) || (r_op == OP_CTZ)) begin
            if (!r_found && !w_scanBit) begin
                w_countNext = r_count + 6'd1;
            end
            if (w_scanBit) begin
                w_foundNext = 1'b1;
            end
        end
        case (r_op)
            OP_CLMUL:  w_finalResult = w_accNext[31:0];
            OP_CLMULH: w_finalResult = w_accNext[63:32];
            OP_CLMULR: w_finalResult = w_accNext[62:31];
            default:   w_finalResult = {26'd0, w_countNext};
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 5'd0;
            r_op     <= 5'd0;
            r_rs1    <= 32'd0;
            r_rs2    <= 32'd0;
            r_acc    <= 64'd0;
            r_count  <= 6'd0;
            r_found  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 32'd0;
        end else if (flush_i) begin
            // Abort wins over any start in the same cycle; result is preserved.
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        r_op  <= BMU_OP_i;
                        r_rs1 <= BMU_RS1_i;
                        r_rs2 <= BMU_RS2_i;
                        if (isLegalOp(BMU_OP_i)) begin
                            r_state <= ST_RUN;
                            r_cnt   <= 5'd0;
                            r_acc   <= 64'd0;
                            r_count <= 6'd0;
                            r_found <= 1'b0;
                        end else begin
                            r_state  <= ST_DONE;
                            r_done   <= 1'b1;
                            r_result <= BMU_RS1_i;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_accNext;
                    r_count <= w_countNext;
                    r_found <= w_foundNext;
                    r_cnt   <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state  <= ST_DONE;
                        r_done   <= 1'b1;
                        r_result <= w_finalResult;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bmu_multicycle.sv
// Randomised and directed bench for bmu_multicycle against a behavioural
// model of the bit-manipulation operations.
module tb_bmu_multicycle;
    import bmu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        flush_i;
    logic [4:0]  BMU_OP_i;
    logic [31:0] BMU_RS1_i;
    logic [31:0] BMU_RS2_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;

    bmu_multicycle dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .flush_i  (flush_i),
        .BMU_OP_i (BMU_OP_i),
        .BMU_RS1_i(BMU_RS1_i),
        .BMU_RS2_i(BMU_RS2_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic bit refLegal(input logic [4:0] op);
        return (op >= 5'd1) && (op <= 5'd6);
    endfunction

    // Reference results from the mathematical definitions of each operation.
    function automatic logic [31:0] refModel(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        int n;
        prod = 64'd0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) prod = prod ^ (64'(a) << i);
        end
        case (op)
            5'd1: return prod[31:0];
            5'd2: return prod[63:32];
            5'd3: return prod[62:31];
            5'd4: begin
                n = 0;
                while (n < 32 && a[31 - n] == 1'b0) n++;
                return 32'(n);
            end
            5'd5: return 32'($countones(a));
            5'd6: begin
                n = 0;
                while (n < 32 && a[n] == 1'b0) n++;
                return 32'(n);
            end
            default: return a;
        endcase
    endfunction

    // Issues one operation and reports edges from the accepting edge to done_o.
    task automatic runOp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int edges, output int busyCycles, output logic [31:0] res,
                         output bit timedOut);
        @(negedge clk_i);
        start_i = 1'b1; BMU_OP_i = op; BMU_RS1_i = a; BMU_RS2_i = b;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        edges = 0; busyCycles = 0; timedOut = 1'b0;
        while (!done_o) begin
            if (busy_o) busyCycles++;
            if (edges >= 100) begin
                timedOut = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
            edges++;
        end
        res = result_o;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        BMU_OP_i = 5'd0; BMU_RS1_i = 32'd0; BMU_RS2_i = 32'd0;
        #2;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl busy=%b done=%b required 0/0", busy_o, done_o);
        end
        checks++;
        if (result_o !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_result got %h required 00000000", result_o);
        end
        @(negedge clk_i); @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_directed();
        logic [4:0]  ops  [7] = '{OP_CLMUL, OP_CLMULH, OP_CLMULR, OP_CLZ, OP_CTZ, OP_CPOP, OP_CTZ};
        logic [31:0] aVal [7] = '{32'h3, 32'h80000000, 32'h80000000, 32'h00010000, 32'h0, 32'hF0F0F0F0, 32'h80000000};
        logic [31:0] bVal [7] = '{32'h3, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [31:0] expV [7] = '{32'h5, 32'h40000000, 32'h80000000, 32'd15, 32'd32, 32'd16, 32'd31};
        int edges, busyCycles;
        logic [31:0] res;
        bit timedOut;
        for (int i = 0; i < 7; i++) begin
            runOp(ops[i], aVal[i], bVal[i], edges, busyCycles, res, timedOut);
            checks++;
            if (timedOut || edges != 32) begin
                errors++;
                $display("[TB] FAIL dir_latency[%0d] edges=%0d timeout=%0d required 32", i, edges, timedOut);
            end
            checks++;
            if (busyCycles != 32) begin
                errors++;
                $display("[TB] FAIL dir_busy[%0d] busy cycles=%0d required 32", i, busyCycles);
            end
            checks++;
            if (res !== expV[i]) begin
                errors++;
                $display("[TB] FAIL dir_result[%0d] got %h required %h", i, res, expV[i]);
            end
            @(posedge clk_i); #1;
            checks++;
            if (done_o !== 1'b0 || result_o !== expV[i]) begin
                errors++;
                $display("[TB] FAIL dir_pulse[%0d] done=%b result=%h required 0/%h", i, done_o, result_o, expV[i]);
            end
        end
    endtask

    task automatic test_random();
        int edges, busyCycles;
        logic [31:0] res, a, b, expV;
        logic [4:0] op;
        bit timedOut;
        int sel;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6) op = 5'(sel + 1);
            else if (sel == 6) op = 5'd0;
            else op = 5'($urandom_range(7, 31));
            a = $urandom();
            b = $urandom();
            if (i % 5 == 0) a = a & ($urandom() >> $urandom_range(0, 31));
            expV = refModel(op, a, b);
            runOp(op, a, b, edges, busyCycles, res, timedOut);
            checks++;
            if (timedOut || edges != (refLegal(op) ? 32 : 0)) begin
                errors++;
                $display("[TB] FAIL rnd_latency op=%0d edges=%0d timeout=%0d required %0d", op, edges, timedOut, refLegal(op) ? 32 : 0);
            end
            checks++;
            if (res !== expV) begin
                errors++;
                $display("[TB] FAIL rnd_result op=%0d a=%h b=%h got %h required %h", op, a, b, res, expV);
            end
        end
    endtask

    task automatic test_flush();
        int edges, busyCycles;
        logic [31:0] res;
        bit timedOut, sawDone;
        runOp(OP_CPOP, 32'h000000FF, 32'h0, edges, busyCycles, res, timedOut);
        checks++;
        if (timedOut || res !== 32'd8) begin
            errors++;
            $display("[TB] FAIL flush_setup got %h required 00000008", res);
        end
        @(negedge clk_i);
        start_i = 1'b1; BMU_OP_i = OP_CPOP; BMU_RS1_i = $urandom();
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'd8) begin
            errors++;
            $display("[TB] FAIL flush_abort busy=%b done=%b result=%h required 0/0/00000008", busy_o, done_o, result_o);
        end
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (done_o || busy_o) sawDone = 1'b1;
        end
        checks++;
        if (sawDone) begin
            errors++;
            $display("[TB] FAIL flush_quiet activity seen after flush, required none");
        end
        @(negedge clk_i);
        start_i = 1'b1; flush_i = 1'b1; BMU_OP_i = OP_CLMUL;
        @(posedge clk_i); #1;
        start_i = 1'b0; flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'd8) begin
            errors++;
            $display("[TB] FAIL flush_start busy=%b done=%b result=%h required 0/0/00000008", busy_o, done_o, result_o);
        end
    endtask

    task automatic test_back_to_back();
        int edges, busyCycles;
        logic [31:0] res;
        bit timedOut;
        runOp(OP_CLMUL, 32'h3, 32'h3, edges, busyCycles, res, timedOut);
        checks++;
        if (timedOut || res !== 32'h5) begin
            errors++;
            $display("[TB] FAIL b2b_first got %h required 00000005", res);
        end
        start_i = 1'b1; BMU_OP_i = OP_CLZ; BMU_RS1_i = 32'h00010000; BMU_RS2_i = 32'h0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_accept busy=%b done=%b required 1/0", busy_o, done_o);
        end
        edges = 0;
        while (!done_o && edges < 100) begin
            @(posedge clk_i); #1;
            edges++;
        end
        checks++;
        if (edges != 32 || result_o !== 32'd15) begin
            errors++;
            $display("[TB] FAIL b2b_second edges=%0d result=%h required 32/0000000f", edges, result_o);
        end
    endtask

    task automatic test_reset_midrun();
        int edges, busyCycles;
        logic [31:0] res;
        bit timedOut;
        @(negedge clk_i);
        start_i = 1'b1; BMU_OP_i = OP_CPOP; BMU_RS1_i = 32'hFFFFFFFF;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #3 rst_i = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'd0) begin
            errors++;
            $display("[TB] FAIL rst_midrun busy=%b done=%b result=%h required 0/0/00000000", busy_o, done_o, result_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        runOp(5'h07, 32'hDEADBEEF, 32'h0, edges, busyCycles, res, timedOut);
        checks++;
        if (timedOut || edges != 0 || busyCycles != 0 || res !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL illegal_op edges=%0d busy=%0d result=%h required 0/0/deadbeef", edges, busyCycles, res);
        end
        @(posedge clk_i); #1;
        checks++;
        if (done_o !== 1'b0 || result_o !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL illegal_pulse done=%b result=%h required 0/deadbeef", done_o, result_o);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bmu_multicycle.md
BMU_MULTICYCLE -- requirements
Module: bmu_multicycle

Interface
REQ-001 SHALL have port clk_i, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit, reset, asynchronous and active-high.
REQ-003 SHALL have port start_i, input, 1 bit, request to begin an operation.
REQ-004 SHALL have port flush_i, input, 1 bit, abort for a pipeline flush.
REQ-005 SHALL have port BMU_OP_i, input, 5 bits, opcode: CLMUL=00001, CLMULH=00010, CLMULR=00011, CLZ=00100, CPOP=00101, CTZ=00110.
REQ-006 SHALL have port BMU_RS1_i, input, 32 bits, operand 1.
REQ-007 SHALL have port BMU_RS2_i, input, 32 bits, operand 2.
REQ-008 SHALL have port busy_o, output, 1 bit, high while an operation is executing.
REQ-009 SHALL have port done_o, output, 1 bit, one-cycle pulse when result_o becomes valid.
REQ-010 SHALL have port result_o, output, 32 bits, registered result.

Function
REQ-011 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-012 SHALL accept start_i only in IDLE or DONE (busy_o low), and SHALL latch op, rs1, rs2 on the accepting edge.
REQ-013 SHALL, on a legal op, move to RUN with a 5-bit step counter cnt=0, and SHALL process one bit per cycle for exactly 32 cycles (cnt 0..31).
REQ-014 SHALL, when cnt=31 in RUN, write the final result to result_o, move to DONE, and assert done_o for exactly the cycle spent in DONE.
REQ-015 SHALL give fixed latency for legal ops: done_o high in the 32nd cycle after the accepting edge, independent of operand values.
REQ-016 SHALL, for an illegal op, go directly to DONE with result_o=rs1 (done_o one cycle after acceptance).
REQ-017 SHALL leave DONE for IDLE when start_i is low, and SHALL accept start_i in DONE (back-to-back) with the same timing as from IDLE.
REQ-018 SHALL drive busy_o = (state==RUN).
REQ-019 SHALL give flush_i priority over everything: it forces IDLE, suppresses done_o in the next cycle, discards any start_i in the same cycle, and leaves result_o unchanged.
REQ-020 CLMUL family: a 64-bit accumulator cleared at acceptance; each step, if rs2[cnt], acc ^= {32'b0,rs1} << cnt.
REQ-021 CLMUL family result select: CLMUL=acc[31:0], CLMULH=acc[63:32], CLMULR=acc[62:31].
REQ-022 CPOP: a 6-bit count cleared at acceptance, incremented when rs1[cnt]=1.
REQ-023 CLZ/CTZ: scan rs1[31-cnt] for CLZ and rs1[cnt] for CTZ; increment the 6-bit count while the found flag is 0 and the scanned bit is 0; set found on the first 1.
REQ-024 All-zero rs1 SHALL yield 32 for CLZ/CTZ; counts SHALL be zero-extended to 32 bits.
REQ-025 result_o SHALL hold its value until the next REQ-014/REQ-016 write.

Reset
REQ-026 SHALL, on rst_i high, asynchronously force state=IDLE, cnt=0, busy_o=0, done_o=0, result_o=0, accumulator=0 and count=0, including mid-RUN.
REQ-027 SHALL start the first accept only on a clock edge where rst_i is low.

Structure
REQ-028 Opcode localparams (shared with the single-cycle BMU encoding) and the FSM state enum typedef SHALL live in bmu_pkg.
REQ-029 The block SHALL be a single module; no sub-module is required, and the per-step datapath SHALL be inline combinational logic feeding registered state.

Verification
REQ-030 CLMUL rs1=0x3, rs2=0x3 -> done_o 32 cycles after start, result_o=0x00000005, busy_o high for exactly 32 cycles.
REQ-031 CLMULH rs1=rs2=0x80000000 -> 0x40000000; CLMULR with the same operands -> 0x80000000.
REQ-032 CLZ 0x00010000 -> 15; CTZ 0x00000000 -> 32; CPOP 0xF0F0F0F0 -> 16; CTZ 0x80000000 -> 31.
REQ-033 Start CPOP, assert flush_i at RUN cycle 10 -> IDLE next cycle, no done_o, result_o keeps its previous value; start_i with flush_i in the same cycle -> ignored.
REQ-034 Back-to-back: start_i held high during DONE with a new CLZ op -> accepted, second done_o exactly 32 cycles later.
REQ-035 rst_i asserted mid-RUN between clock edges -> outputs zero immediately; illegal op 0x07 with rs1=0xDEADBEEF -> done_o one cycle later, result_o=0xDEADBEEF.
